// File: rtl/i2c_ball_pkg.sv
// i2c_ball_pkg
// Shared definitions for the ball hand-off I2C target: FSM state encoding,
// number of ball registers, default bus address and the byte-index names
// that map frame byte positions onto the game controller registers.
package i2c_ball_pkg;

  localparam int NUM_BALL_REGS = 6;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h12;

  // Position of each ball field inside the write frame
  localparam int IDX_Y0        = 0;
  localparam int IDX_Y1        = 1;
  localparam int IDX_YSPEED    = 2;
  localparam int IDX_GRAVITY   = 3;
  localparam int IDX_BALLSPEED = 4;
  localparam int IDX_WIN       = 5;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_ADDR_ACK  = 3'd2,
    S_RX_BYTE   = 3'd3,
    S_RX_ACK    = 3'd4,
    S_TX_BYTE   = 3'd5,
    S_TX_ACK    = 3'd6,
    S_WAIT_STOP = 3'd7
  } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync
// Brings the raw SCL/SDA pin levels into the clk_25MHZ domain and derives
// the bus events the protocol FSM needs. All outputs are registered, so an
// event appears SYNC_STAGES+1 clocks after the pin edge.
//
// Ports:
//   clk_25MHZ  in   system clock
//   reset_n    in   asynchronous active-low reset
//   scl_in     in   raw SCL pin
//   sda_in     in   raw SDA pin
//   scl_rise   out  one-clock pulse on a synchronized SCL rising edge
//   scl_fall   out  one-clock pulse on a synchronized SCL falling edge
//   sda_s      out  synchronized SDA, aligned with the pulses above
//   start_det  out  one-clock pulse: SDA fell while SCL high
//   stop_det   out  one-clock pulse: SDA rose while SCL high
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_25MHZ,
  input  logic reset_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_d;
  logic                   sda_d;
  logic                   scl_now;
  logic                   sda_now;

  assign scl_now = scl_sync[SYNC_STAGES-1];
  assign sda_now = sda_sync[SYNC_STAGES-1];

  // Synchronizer chains plus one history flop per line. Everything resets to
  // the idle-bus level (high) so leaving reset never fakes a START or STOP.
  always_ff @(posedge clk_25MHZ or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync  <= '1;
      sda_sync  <= '1;
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
      sda_s     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[SYNC_STAGES-2:0], scl_in};
      sda_sync  <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      scl_d     <= scl_now;
      sda_d     <= sda_now;
      sda_s     <= sda_now;
      scl_rise  <= scl_now & ~scl_d;
      scl_fall  <= ~scl_now & scl_d;
      // SCL must be high on both samples so an SDA change that coincides
      // with an SCL edge is never taken as START/STOP
      start_det <= scl_now & scl_d & ~sda_now & sda_d;
      stop_det  <= scl_now & scl_d & sda_now & ~sda_d;
    end
  end

endmodule

// File: rtl/i2c_ball_slave.sv
// i2c_ball_slave
// Receive-side I2C target for the two-board ball hand-off. Decodes the write
// frame from the opposing board, collects six ball bytes into a shadow copy
// and commits them to the controller-facing registers on a clean STOP.
// is_slave_done stays high until the controller answers with responsing_i2c;
// while it is high, new write frames are refused at the address byte.
//
// Optional feature: define I2C_READBACK_EN to let the master read the
// committed registers back (R/W=1), pointer starting at register 0 and
// wrapping after register 5. Without it, read addresses are NACKed.
//
// Ports:
//   clk_25MHZ            in   system clock (only clock)
//   reset_n              in   asynchronous active-low reset
//   scl_in, sda_in       in   raw bus pin levels
//   sda_oe               out  1 = pull SDA low
//   slv_reg0..5          out  committed ball bytes (y0, y1, Yspeed, gravity,
//                             ball speed, win flag)
//   is_slave_done        out  frame committed, waiting for acknowledge
//   responsing_i2c       in   controller acknowledge of is_slave_done
//   frame_error          out  one-clock pulse when a write frame is discarded
module i2c_ball_slave
  import i2c_ball_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = DEFAULT_SLAVE_ADDR,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk_25MHZ,
  input  logic              reset_n,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic        [7:0] slv_reg0_y0,
  output logic        [7:0] slv_reg1_y1,
  output logic signed [7:0] slv_reg2_Yspeed,
  output logic        [7:0] slv_reg3_gravity,
  output logic        [7:0] slv_reg4_ballspeed,
  output logic        [7:0] slv_reg5_win_flag,
  output logic              is_slave_done,
  input  logic              responsing_i2c,
  output logic              frame_error
);

  localparam logic [2:0] IDLE      = S_IDLE;
  localparam logic [2:0] ADDR      = S_ADDR;
  localparam logic [2:0] ADDR_ACK  = S_ADDR_ACK;
  localparam logic [2:0] RX_BYTE   = S_RX_BYTE;
  localparam logic [2:0] RX_ACK    = S_RX_ACK;
  localparam logic [2:0] WAIT_STOP = S_WAIT_STOP;
`ifdef I2C_READBACK_EN
  localparam logic [2:0] TX_BYTE   = S_TX_BYTE;
  localparam logic [2:0] TX_ACK    = S_TX_ACK;
`endif

  localparam logic [2:0] FULL_IDX = 3'(NUM_BALL_REGS);

  logic       scl_rise;
  logic       scl_fall;
  logic       sda_s;
  logic       start_det;
  logic       stop_det;

  logic [2:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_q;
  logic       byte_full;
  logic [2:0] byte_idx;
  logic [7:0] shadow [NUM_BALL_REGS];
  logic [7:0] regs   [NUM_BALL_REGS];
  logic       frame_write;
  logic       frame_bad;
  logic       sda_oe_q;
  logic       done_q;
  logic       frame_error_q;
  logic       addr_match;
  logic       commit_ok;

`ifdef I2C_READBACK_EN
  logic       addr_is_read;
  logic [2:0] tx_ptr;
  logic [2:0] tx_next;
  logic [7:0] tx_shift;
  logic       master_ack;

  assign tx_next = (tx_ptr == FULL_IDX - 3'd1) ? 3'd0 : tx_ptr + 3'd1;
`endif

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk_25MHZ(clk_25MHZ),
    .reset_n  (reset_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .sda_s    (sda_s),
    .start_det(start_det),
    .stop_det (stop_det)
  );

  assign addr_match = (shift_q[7:1] == SLAVE_ADDR);

  // A write frame is only worth committing when exactly six bytes arrived
  // and nothing was NACKed along the way
  assign commit_ok = frame_write && (byte_idx == FULL_IDX) && !frame_bad;

  // Protocol FSM. Bits are shifted in on SCL rise; every decision that moves
  // sda_oe waits for the following SCL fall, so the line only ever changes
  // while SCL is low. START and STOP override whatever the FSM was doing.
  always_ff @(posedge clk_25MHZ or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shift_q     <= 8'd0;
      byte_full   <= 1'b0;
      byte_idx    <= 3'd0;
      frame_write <= 1'b0;
      frame_bad   <= 1'b0;
      sda_oe_q    <= 1'b0;
      for (int i = 0; i < NUM_BALL_REGS; i++) shadow[i] <= 8'd0;
`ifdef I2C_READBACK_EN
      addr_is_read <= 1'b0;
      tx_ptr       <= 3'd0;
      tx_shift     <= 8'd0;
      master_ack   <= 1'b0;
`endif
    end else if (start_det) begin
      state       <= ADDR;
      bit_cnt     <= 3'd0;
      byte_full   <= 1'b0;
      byte_idx    <= 3'd0;
      frame_write <= 1'b0;
      frame_bad   <= 1'b0;
      sda_oe_q    <= 1'b0;
      for (int i = 0; i < NUM_BALL_REGS; i++) shadow[i] <= 8'd0;
    end else if (stop_det) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      byte_full   <= 1'b0;
      frame_write <= 1'b0;
      frame_bad   <= 1'b0;
      sda_oe_q    <= 1'b0;
    end else begin
      case (state)
        ADDR, RX_BYTE: begin
          if (scl_rise && !byte_full) begin
            shift_q <= {shift_q[6:0], sda_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) byte_full <= 1'b1;
          end else if (scl_fall && byte_full) begin
            byte_full <= 1'b0;
            if (state == ADDR) begin
              // Busy (done still set) refuses writes so an unacknowledged
              // frame can never be overwritten
              if (addr_match && !shift_q[0] && !done_q) begin
                sda_oe_q    <= 1'b1;
                frame_write <= 1'b1;
                state       <= ADDR_ACK;
`ifdef I2C_READBACK_EN
                addr_is_read <= 1'b0;
              end else if (addr_match && shift_q[0]) begin
                sda_oe_q     <= 1'b1;
                addr_is_read <= 1'b1;
                state        <= ADDR_ACK;
`endif
              end else begin
                state <= WAIT_STOP;
              end
            end else if (byte_idx < FULL_IDX) begin
              shadow[byte_idx] <= shift_q;
              byte_idx         <= byte_idx + 3'd1;
              sda_oe_q         <= 1'b1;
              state            <= RX_ACK;
            end else begin
              frame_bad <= 1'b1;
              state     <= WAIT_STOP;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            bit_cnt <= 3'd0;
`ifdef I2C_READBACK_EN
            if (addr_is_read) begin
              // First data bit goes out on the same fall that ends the ACK
              tx_ptr   <= 3'd0;
              sda_oe_q <= ~regs[0][7];
              tx_shift <= {regs[0][6:0], 1'b0};
              state    <= TX_BYTE;
            end else begin
              sda_oe_q <= 1'b0;
              state    <= RX_BYTE;
            end
`else
            sda_oe_q <= 1'b0;
            state    <= RX_BYTE;
`endif
          end
        end

        RX_ACK: begin
          if (scl_fall) begin
            sda_oe_q <= 1'b0;
            bit_cnt  <= 3'd0;
            state    <= RX_BYTE;
          end
        end

`ifdef I2C_READBACK_EN
        TX_BYTE: begin
          if (scl_fall) begin
            if (bit_cnt == 3'd7) begin
              sda_oe_q <= 1'b0;
              bit_cnt  <= 3'd0;
              state    <= TX_ACK;
            end else begin
              sda_oe_q <= ~tx_shift[7];
              tx_shift <= {tx_shift[6:0], 1'b0};
              bit_cnt  <= bit_cnt + 3'd1;
            end
          end
        end

        TX_ACK: begin
          if (scl_rise) begin
            master_ack <= ~sda_s;
          end else if (scl_fall) begin
            if (master_ack) begin
              tx_ptr   <= tx_next;
              sda_oe_q <= ~regs[tx_next][7];
              tx_shift <= {regs[tx_next][6:0], 1'b0};
              bit_cnt  <= 3'd0;
              state    <= TX_BYTE;
            end else begin
              state <= WAIT_STOP;
            end
          end
        end
`endif

        IDLE, WAIT_STOP: begin
          state <= state;
        end

        default: begin
          state    <= IDLE;
          sda_oe_q <= 1'b0;
        end
      endcase
    end
  end

  // Commit / handshake. Runs on the clock stop_det is high, so registers and
  // done move one clock after STOP detection. A commit on the same clock as
  // an acknowledge wins, so the new frame is never lost.
  always_ff @(posedge clk_25MHZ or negedge reset_n) begin
    if (!reset_n) begin
      done_q        <= 1'b0;
      frame_error_q <= 1'b0;
      for (int i = 0; i < NUM_BALL_REGS; i++) regs[i] <= 8'd0;
    end else begin
      frame_error_q <= 1'b0;
      if (stop_det && commit_ok) begin
        for (int i = 0; i < NUM_BALL_REGS; i++) regs[i] <= shadow[i];
        done_q <= 1'b1;
      end else begin
        if (stop_det && frame_write && (byte_idx != 3'd0 || frame_bad)) begin
          frame_error_q <= 1'b1;
        end
        if (responsing_i2c) done_q <= 1'b0;
      end
    end
  end

  assign sda_oe             = sda_oe_q;
  assign is_slave_done      = done_q;
  assign frame_error        = frame_error_q;
  assign slv_reg0_y0        = regs[IDX_Y0];
  assign slv_reg1_y1        = regs[IDX_Y1];
  assign slv_reg2_Yspeed    = regs[IDX_YSPEED];
  assign slv_reg3_gravity   = regs[IDX_GRAVITY];
  assign slv_reg4_ballspeed = regs[IDX_BALLSPEED];
  assign slv_reg5_win_flag  = regs[IDX_WIN];

endmodule

// File: tb/tb_i2c_ball_slave.sv
// tb_i2c_ball_slave
// Directed bench for i2c_ball_slave: a bit-banged I2C master drives SCL/SDA
// (10 clk_25MHZ cycles per SCL phase) and every expected value is written
// out by hand below. Define I2C_READBACK_EN for both files to cover reads.
module tb_i2c_ball_slave;

  logic       clk_25MHZ = 1'b0;
  logic       reset_n   = 1'b0;
  logic       scl_m     = 1'b1;
  logic       sda_m     = 1'b1;
  logic       responsing_i2c = 1'b0;
  logic       sda_oe;
  logic       is_slave_done;
  logic       frame_error;
  logic [7:0] r0, r1, r2, r3, r4, r5;
  logic       sda_line;

  int n_checks   = 0;
  int n_fail     = 0;
  int err_pulses = 0;
  int oe_cycles  = 0;

  logic       addr_ack;
  logic       byte_ack [8];
  logic [7:0] wr_data  [8];
  logic       done_tr  [1:6];
  logic       err_tr   [1:6];

  // Open-drain bus: either side pulling low wins
  assign sda_line = sda_m & ~sda_oe;

  always #20 clk_25MHZ = ~clk_25MHZ;

  i2c_ball_slave dut (
    .clk_25MHZ         (clk_25MHZ),
    .reset_n           (reset_n),
    .scl_in            (scl_m),
    .sda_in            (sda_line),
    .sda_oe            (sda_oe),
    .slv_reg0_y0       (r0),
    .slv_reg1_y1       (r1),
    .slv_reg2_Yspeed   (r2),
    .slv_reg3_gravity  (r3),
    .slv_reg4_ballspeed(r4),
    .slv_reg5_win_flag (r5),
    .is_slave_done     (is_slave_done),
    .responsing_i2c    (responsing_i2c),
    .frame_error       (frame_error)
  );

  always @(posedge clk_25MHZ) begin
    if (frame_error) err_pulses++;
    if (sda_oe) oe_cycles++;
  end

  initial begin
    #4000000;
    $display("[TB] FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_25MHZ);
  endtask

  task automatic check_regs(input string tag, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3,
                            input logic [7:0] e4, input logic [7:0] e5);
    checkOutput({tag, " reg0"}, 32'(r0), 32'(e0));
    checkOutput({tag, " reg1"}, 32'(r1), 32'(e1));
    checkOutput({tag, " reg2"}, 32'(r2), 32'(e2));
    checkOutput({tag, " reg3"}, 32'(r3), 32'(e3));
    checkOutput({tag, " reg4"}, 32'(r4), 32'(e4));
    checkOutput({tag, " reg5"}, 32'(r5), 32'(e5));
  endtask

  task automatic i2c_start;
    sda_m = 1'b1;
    scl_m = 1'b1;
    tick(10);
    sda_m = 1'b0;
    tick(10);
    scl_m = 1'b0;
    tick(2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      sda_m = b[i];
      tick(10);
      scl_m = 1'b1;
      tick(10);
      scl_m = 1'b0;
    end
    sda_m = 1'b1;
    tick(10);
    scl_m = 1'b1;
    tick(5);
    ack = ~sda_line;
    tick(5);
    scl_m = 1'b0;
  endtask

  task automatic recv_byte(input logic give_ack, output logic [7:0] b);
    sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      tick(10);
      scl_m = 1'b1;
      tick(5);
      b[i] = sda_line;
      tick(5);
      scl_m = 1'b0;
    end
    sda_m = ~give_ack;
    tick(10);
    scl_m = 1'b1;
    tick(10);
    scl_m = 1'b0;
    sda_m = 1'b1;
  endtask

  // STOP with a trace of done/frame_error for the six clocks after the
  // SDA pin rises; detection lands 3 clocks later, commit 1 clock after that
  task automatic i2c_stop;
    sda_m = 1'b0;
    tick(10);
    scl_m = 1'b1;
    tick(10);
    sda_m = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      done_tr[k] = is_slave_done;
      err_tr[k]  = frame_error;
    end
    tick(10);
  endtask

  task automatic applyStimulus(input logic [7:0] addr_byte, input int n);
    i2c_start();
    send_byte(addr_byte, addr_ack);
    for (int i = 0; i < n; i++) send_byte(wr_data[i], byte_ack[i]);
    i2c_stop();
  endtask

  task automatic load_data(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input logic [7:0] d3, input logic [7:0] d4, input logic [7:0] d5,
                           input logic [7:0] d6);
    wr_data[0] = d0; wr_data[1] = d1; wr_data[2] = d2; wr_data[3] = d3;
    wr_data[4] = d4; wr_data[5] = d5; wr_data[6] = d6; wr_data[7] = 8'h00;
  endtask

  task automatic respond;
    responsing_i2c = 1'b1;
    tick(1);
    responsing_i2c = 1'b0;
  endtask

  initial begin
    int e0;
    int o0;
    logic [7:0] rb;
    logic       ack;

    // Reset state
    tick(5);
    check_regs("reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("reset done", 32'(is_slave_done), 32'd0);
    checkOutput("reset sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("reset frame_error", 32'(frame_error), 32'd0);
    reset_n = 1'b1;
    tick(5);

    // Frame A: full valid write
    load_data(8'h40, 8'hDC, 8'hFD, 8'h02, 8'h01, 8'h01, 8'h00);
    e0 = err_pulses;
    applyStimulus(8'h24, 6);
    checkOutput("A addr ack", 32'(addr_ack), 32'd1);
    for (int i = 0; i < 6; i++) checkOutput("A byte ack", 32'(byte_ack[i]), 32'd1);
    checkOutput("A done before commit", 32'(done_tr[3]), 32'd0);
    checkOutput("A done at commit", 32'(done_tr[4]), 32'd1);
    checkOutput("A no error", 32'(err_pulses - e0), 32'd0);
    check_regs("A", 8'h40, 8'hDC, 8'hFD, 8'h02, 8'h01, 8'h01);

    respond();
    checkOutput("A done after ack", 32'(is_slave_done), 32'd0);
    check_regs("A retained", 8'h40, 8'hDC, 8'hFD, 8'h02, 8'h01, 8'h01);
    respond();
    checkOutput("ack with done=0", 32'(is_slave_done), 32'd0);

    // Wrong address 0x13
    e0 = err_pulses;
    o0 = oe_cycles;
    applyStimulus(8'h26, 0);
    checkOutput("0x13 addr ack", 32'(addr_ack), 32'd0);
    checkOutput("0x13 sda_oe cycles", 32'(oe_cycles - o0), 32'd0);
    checkOutput("0x13 no error", 32'(err_pulses - e0), 32'd0);
    checkOutput("0x13 done", 32'(is_slave_done), 32'd0);
    check_regs("0x13", 8'h40, 8'hDC, 8'hFD, 8'h02, 8'h01, 8'h01);

    // Short frame: 4 bytes
    load_data(8'h99, 8'h98, 8'h97, 8'h96, 8'h00, 8'h00, 8'h00);
    e0 = err_pulses;
    applyStimulus(8'h24, 4);
    checkOutput("short byte3 ack", 32'(byte_ack[3]), 32'd1);
    checkOutput("short err before", 32'(err_tr[3]), 32'd0);
    checkOutput("short err at commit", 32'(err_tr[4]), 32'd1);
    checkOutput("short err after", 32'(err_tr[5]), 32'd0);
    checkOutput("short err pulses", 32'(err_pulses - e0), 32'd1);
    checkOutput("short done", 32'(done_tr[6]), 32'd0);
    check_regs("short", 8'h40, 8'hDC, 8'hFD, 8'h02, 8'h01, 8'h01);

    // Long frame: 7 bytes
    load_data(8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60, 8'h70);
    e0 = err_pulses;
    applyStimulus(8'h24, 7);
    checkOutput("long byte6 ack", 32'(byte_ack[5]), 32'd1);
    checkOutput("long byte7 nack", 32'(byte_ack[6]), 32'd0);
    checkOutput("long err at commit", 32'(err_tr[4]), 32'd1);
    checkOutput("long err pulses", 32'(err_pulses - e0), 32'd1);
    checkOutput("long done", 32'(done_tr[6]), 32'd0);
    check_regs("long", 8'h40, 8'hDC, 8'hFD, 8'h02, 8'h01, 8'h01);

    // Frame B commits, then C is refused while busy
    load_data(8'h11, 8'h22, 8'h83, 8'h44, 8'h55, 8'h00, 8'h00);
    applyStimulus(8'h24, 6);
    checkOutput("B done", 32'(is_slave_done), 32'd1);
    check_regs("B", 8'h11, 8'h22, 8'h83, 8'h44, 8'h55, 8'h00);

    load_data(8'hA5, 8'h5A, 8'h7F, 8'h80, 8'h01, 8'hFE, 8'h00);
    e0 = err_pulses;
    applyStimulus(8'h24, 0);
    checkOutput("busy addr ack", 32'(addr_ack), 32'd0);
    checkOutput("busy no error", 32'(err_pulses - e0), 32'd0);
    checkOutput("busy done held", 32'(is_slave_done), 32'd1);
    check_regs("busy", 8'h11, 8'h22, 8'h83, 8'h44, 8'h55, 8'h00);

    respond();
    checkOutput("B acked", 32'(is_slave_done), 32'd0);
    applyStimulus(8'h24, 6);
    checkOutput("C addr ack", 32'(addr_ack), 32'd1);
    checkOutput("C done", 32'(is_slave_done), 32'd1);
    check_regs("C", 8'hA5, 8'h5A, 8'h7F, 8'h80, 8'h01, 8'hFE);

    // Reset in the middle of a frame
    respond();
    i2c_start();
    send_byte(8'h24, ack);
    checkOutput("mid addr ack", 32'(ack), 32'd1);
    for (int i = 0; i < 3; i++) send_byte(8'hEE, ack);
    reset_n = 1'b0;
    tick(2);
    check_regs("mid reset", 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    checkOutput("mid reset done", 32'(is_slave_done), 32'd0);
    checkOutput("mid reset sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("mid reset frame_error", 32'(frame_error), 32'd0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    tick(3);
    reset_n = 1'b1;
    tick(5);

    load_data(8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h00);
    applyStimulus(8'h24, 6);
    checkOutput("D done", 32'(is_slave_done), 32'd1);
    check_regs("D", 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);

    // Read access
`ifdef I2C_READBACK_EN
    i2c_start();
    send_byte(8'h25, ack);
    checkOutput("read addr ack", 32'(ack), 32'd1);
    for (int i = 0; i < 7; i++) begin
      recv_byte(i < 6, rb);
      checkOutput("read byte", 32'(rb), 32'(i % 6 + 1));
    end
    i2c_stop();
    checkOutput("read done kept", 32'(is_slave_done), 32'd1);
`else
    o0 = oe_cycles;
    rb = 8'h00;
    i2c_start();
    send_byte(8'h25, ack);
    i2c_stop();
    checkOutput("read addr nack", 32'(ack), 32'd0);
    checkOutput("read sda_oe cycles", 32'(oe_cycles - o0), 32'(rb));
    checkOutput("read done kept", 32'(is_slave_done), 32'd1);
`endif
    check_regs("after read", 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
